full_pipeline: RTL and testbench

Top level of the five-stage in-order RV64 integer pipeline (IF, ID, EX, MEM, WB). It contains the program counter, a byte-addressed instruction memory, the register file, the ALU, a byte-addressed data memory, forwarding and hazard logic. Benches preload instruction memory hierarchically and observe execution through the hierarchy. There are no functional outputs.

---
 rtl/full_pipeline.sv | 366 ++++++++++++++++++++++++++++++++++++
 tb/tb_full_pipeline.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/full_pipeline.sv
// Five-stage in-order RV64 integer pipeline: IF, ID, EX, MEM, WB with forwarding,
// load-use stall and branch resolution in EX.

// Byte-addressed instruction ROM, loaded from outside the design.
module fp_instr_mem (
  input  logic [9:0]  addr,
  output logic [31:0] rdata
);
  logic [7:0] mem [0:1023];

  // Little-endian word fetch; the 10-bit byte addresses wrap at 1024
  always_comb begin
    rdata = {mem[addr + 10'd3], mem[addr + 10'd2], mem[addr + 10'd1], mem[addr]};
  end
endmodule

// Fetch stage: program counter and instruction memory.
module fp_if_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] target,
  output logic [63:0] pc,
  output logic [31:0] instr
);
  logic [63:0] PC_F;

  // PC update: a taken branch overrides a stall
  always_ff @(posedge clk) begin
    if (!reset) begin
      PC_F <= '0;
    end else if (redirect) begin
      PC_F <= target;
    end else if (!stall) begin
      PC_F <= PC_F + 64'd4;
    end
  end

  assign pc = PC_F;

  fp_instr_mem instr_mem (
    .addr  (PC_F[9:0]),
    .rdata (instr)
  );
endmodule

// 32 x 64-bit register file with x0 hardwired to zero and WB-to-ID bypass.
module fp_reg_file (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [63:0] rd1,
  output logic [63:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [63:0] wd
);
  logic [63:0] regs [0:31];

  // Register write; writes to x0 are dropped
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  // Reads see a same-cycle write so WB and ID can overlap
  always_comb begin
    rd1 = regs[ra1];
    rd2 = regs[ra2];
    if (we && wa != 5'd0 && wa == ra1) rd1 = wd;
    if (we && wa != 5'd0 && wa == ra2) rd2 = wd;
    if (ra1 == 5'd0) rd1 = '0;
    if (ra2 == 5'd0) rd2 = '0;
  end
endmodule

// 256-byte data memory with wrapping 64-bit little-endian accesses.
module fp_data_mem (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  addr,
  input  logic        we,
  input  logic [63:0] wdata,
  output logic [63:0] rdata
);
  logic [7:0] mem [0:255];

  // Store of eight bytes; byte addresses wrap past 255
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (we) begin
      for (int k = 0; k < 8; k++) mem[addr + 8'(k)] <= wdata[8*k +: 8];
    end
  end

  // Combinational load of eight bytes
  always_comb begin
    rdata = '0;
    for (int k = 0; k < 8; k++) rdata[8*k +: 8] = mem[addr + 8'(k)];
  end
endmodule

module full_pipeline (
  input logic clk,
  input logic reset
);
  localparam int unsigned XLEN = 64;

  localparam logic [6:0] OPC_OP        = 7'h33;
  localparam logic [6:0] OPC_OP_IMM    = 7'h13;
  localparam logic [6:0] OPC_OP_32     = 7'h3B;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'h1B;
  localparam logic [6:0] OPC_LOAD      = 7'h03;
  localparam logic [6:0] OPC_STORE     = 7'h23;
  localparam logic [6:0] OPC_BRANCH    = 7'h63;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    branch_ne;
    logic    use_imm;
    logic    word_op;
    alu_op_e alu_op;
  } ctrl_t;

  logic [XLEN-1:0] pc_f;
  logic [31:0]     if_instr;
  logic            load_use;
  logic            ex_taken;
  logic [XLEN-1:0] ex_target;

  logic [31:0]     ifid_instr;
  logic [XLEN-1:0] ifid_pc;

  ctrl_t           id_ctrl;
  logic [XLEN-1:0] id_imm;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0] id_rs1_val, id_rs2_val;

  ctrl_t           idex_ctrl;
  logic [XLEN-1:0] idex_pc, idex_imm, idex_rs1_val, idex_rs2_val;
  logic [4:0]      idex_rs1, idex_rs2, idex_rd;

  logic [XLEN-1:0] ex_fa, ex_fb, ex_b, alu_raw, ex_result;

  logic            exmem_reg_write, exmem_mem_read, exmem_mem_write;
  logic [4:0]      exmem_rd;
  logic [XLEN-1:0] exmem_result, exmem_store;
  logic [XLEN-1:0] mem_rdata;

  logic            memwb_reg_write;
  logic [4:0]      memwb_rd;
  logic [XLEN-1:0] memwb_data;

  fp_if_stage if_stage (
    .clk      (clk),
    .reset    (reset),
    .stall    (load_use),
    .redirect (ex_taken),
    .target   (ex_target),
    .pc       (pc_f),
    .instr    (if_instr)
  );

  // IF/ID register: flushed on a taken branch, held on a load-use stall
  always_ff @(posedge clk) begin
    if (!reset) begin
      ifid_instr <= '0;
      ifid_pc    <= '0;
    end else if (ex_taken) begin
      ifid_instr <= '0;
      ifid_pc    <= '0;
    end else if (!load_use) begin
      ifid_instr <= if_instr;
      ifid_pc    <= pc_f;
    end
  end

  assign id_rs1 = ifid_instr[19:15];
  assign id_rs2 = ifid_instr[24:20];
  assign id_rd  = ifid_instr[11:7];

  // Decode; anything unrecognised leaves all controls cleared (NOP)
  always_comb begin
    id_ctrl = '0;
    id_imm  = {{52{ifid_instr[31]}}, ifid_instr[31:20]};
    unique case (ifid_instr[6:0])
      OPC_OP, OPC_OP_IMM: begin
        id_ctrl.reg_write = 1'b1;
        id_ctrl.use_imm   = (ifid_instr[6:0] == OPC_OP_IMM);
        unique case (ifid_instr[14:12])
          3'b000:  id_ctrl.alu_op = (ifid_instr[30] && ifid_instr[6:0] == OPC_OP) ? ALU_SUB : ALU_ADD;
          3'b001:  id_ctrl.alu_op = ALU_SLL;
          3'b010:  id_ctrl.alu_op = ALU_SLT;
          3'b011:  id_ctrl.alu_op = ALU_SLTU;
          3'b100:  id_ctrl.alu_op = ALU_XOR;
          3'b101:  id_ctrl.alu_op = ifid_instr[30] ? ALU_SRA : ALU_SRL;
          3'b110:  id_ctrl.alu_op = ALU_OR;
          default: id_ctrl.alu_op = ALU_AND;
        endcase
      end
      OPC_OP_32: begin
        if (ifid_instr[14:12] == 3'b000) begin
          id_ctrl.reg_write = 1'b1;
          id_ctrl.word_op   = 1'b1;
          id_ctrl.alu_op    = ifid_instr[30] ? ALU_SUB : ALU_ADD;
        end
      end
      OPC_OP_IMM_32: begin
        if (ifid_instr[14:12] == 3'b000) begin
          id_ctrl.reg_write = 1'b1;
          id_ctrl.word_op   = 1'b1;
          id_ctrl.use_imm   = 1'b1;
        end
      end
      OPC_LOAD: begin
        if (ifid_instr[14:12] == 3'b011) begin
          id_ctrl.reg_write = 1'b1;
          id_ctrl.mem_read  = 1'b1;
          id_ctrl.use_imm   = 1'b1;
        end
      end
      OPC_STORE: begin
        id_imm = {{52{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
        if (ifid_instr[14:12] == 3'b011) begin
          id_ctrl.mem_write = 1'b1;
          id_ctrl.use_imm   = 1'b1;
        end
      end
      OPC_BRANCH: begin
        id_imm = {{51{ifid_instr[31]}}, ifid_instr[31], ifid_instr[7],
                  ifid_instr[30:25], ifid_instr[11:8], 1'b0};
        if (ifid_instr[14:13] == 2'b00) begin
          id_ctrl.branch    = 1'b1;
          id_ctrl.branch_ne = ifid_instr[12];
        end
      end
      default: ;
    endcase
  end

  fp_reg_file reg_file (
    .clk   (clk),
    .reset (reset),
    .ra1   (id_rs1),
    .ra2   (id_rs2),
    .rd1   (id_rs1_val),
    .rd2   (id_rs2_val),
    .we    (memwb_reg_write),
    .wa    (memwb_rd),
    .wd    (memwb_data)
  );

  assign load_use = idex_ctrl.mem_read && (idex_rd == id_rs1 || idex_rd == id_rs2);

  // ID/EX register: a bubble replaces the ID instruction on stall or flush
  always_ff @(posedge clk) begin
    if (!reset || ex_taken || load_use) begin
      idex_ctrl    <= '0;
      idex_pc      <= '0;
      idex_imm     <= '0;
      idex_rs1_val <= '0;
      idex_rs2_val <= '0;
      idex_rs1     <= '0;
      idex_rs2     <= '0;
      idex_rd      <= '0;
    end else begin
      idex_ctrl    <= id_ctrl;
      idex_pc      <= ifid_pc;
      idex_imm     <= id_imm;
      idex_rs1_val <= id_rs1_val;
      idex_rs2_val <= id_rs2_val;
      idex_rs1     <= id_rs1;
      idex_rs2     <= id_rs2;
      idex_rd      <= id_rd;
    end
  end

  // Operand forwarding: EX/MEM beats MEM/WB beats the register file
  always_comb begin
    ex_fa = idex_rs1_val;
    ex_fb = idex_rs2_val;
    if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == idex_rs1) ex_fa = memwb_data;
    if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == idex_rs2) ex_fb = memwb_data;
    if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == idex_rs1) ex_fa = exmem_result;
    if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == idex_rs2) ex_fb = exmem_result;
  end

  assign ex_b = idex_ctrl.use_imm ? idex_imm : ex_fb;

  // ALU; word ops sign-extend the low 32 bits of the result
  always_comb begin
    alu_raw = '0;
    unique case (idex_ctrl.alu_op)
      ALU_ADD:  alu_raw = ex_fa + ex_b;
      ALU_SUB:  alu_raw = ex_fa - ex_b;
      ALU_AND:  alu_raw = ex_fa & ex_b;
      ALU_OR:   alu_raw = ex_fa | ex_b;
      ALU_XOR:  alu_raw = ex_fa ^ ex_b;
      ALU_SLL:  alu_raw = ex_fa << ex_b[5:0];
      ALU_SRL:  alu_raw = ex_fa >> ex_b[5:0];
      ALU_SRA:  alu_raw = $signed(ex_fa) >>> ex_b[5:0];
      ALU_SLT:  alu_raw = {63'd0, $signed(ex_fa) < $signed(ex_b)};
      ALU_SLTU: alu_raw = {63'd0, ex_fa < ex_b};
      default:  alu_raw = '0;
    endcase
    ex_result = idex_ctrl.word_op ? {{32{alu_raw[31]}}, alu_raw[31:0]} : alu_raw;
  end

  assign ex_taken  = idex_ctrl.branch && ((ex_fa == ex_fb) != idex_ctrl.branch_ne);
  assign ex_target = idex_pc + idex_imm;

  // EX/MEM register
  always_ff @(posedge clk) begin
    if (!reset) begin
      exmem_reg_write <= 1'b0;
      exmem_mem_read  <= 1'b0;
      exmem_mem_write <= 1'b0;
      exmem_rd        <= '0;
      exmem_result    <= '0;
      exmem_store     <= '0;
    end else begin
      exmem_reg_write <= idex_ctrl.reg_write;
      exmem_mem_read  <= idex_ctrl.mem_read;
      exmem_mem_write <= idex_ctrl.mem_write;
      exmem_rd        <= idex_rd;
      exmem_result    <= ex_result;
      exmem_store     <= ex_fb;
    end
  end

  fp_data_mem data_mem (
    .clk   (clk),
    .reset (reset),
    .addr  (exmem_result[7:0]),
    .we    (exmem_mem_write),
    .wdata (exmem_store),
    .rdata (mem_rdata)
  );

  // MEM/WB register carries the final write-back value
  always_ff @(posedge clk) begin
    if (!reset) begin
      memwb_reg_write <= 1'b0;
      memwb_rd        <= '0;
      memwb_data      <= '0;
    end else begin
      memwb_reg_write <= exmem_reg_write;
      memwb_rd        <= exmem_rd;
      memwb_data      <= exmem_mem_read ? mem_rdata : exmem_result;
    end
  end
endmodule

// File: tb/tb_full_pipeline.sv
// Directed programs for full_pipeline; write-backs are checked by a scoreboard monitor.
module tb_full_pipeline;
  logic clk = 1'b0;
  logic reset = 1'b0;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] val;
  } wb_t;

  wb_t         exp_q[$];
  wb_t         mon_e;
  logic [31:0] prog[$];
  int          checks = 0;
  int          errors = 0;

  full_pipeline dut (.clk(clk), .reset(reset));

  always #5 clk = ~clk;

  // Encoders for the handful of instruction formats used below
  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
    return {imm[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
  endfunction
  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd, input int op);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
  endfunction
  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    return {imm[11:5], 5'(rs2), 5'(rs1), 3'b011, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    return {imm[12], imm[10:5], 5'(rs2), 5'(rs1), 3'(f3), imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return enc_i(imm, rs1, 0, rd, 'h13);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_wb(input int rd, input logic [63:0] v);
    wb_t e;
    e.rd  = 5'(rd);
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    step(2);
    chk("reset_pc", dut.if_stage.PC_F, 64'd0);
  endtask

  task automatic load_prog();
    for (int i = 0; i < 1024; i++) dut.if_stage.instr_mem.mem[i] = 8'h00;
    for (int i = 0; i < prog.size(); i++)
      for (int b = 0; b < 4; b++) dut.if_stage.instr_mem.mem[4*i+b] = prog[i][8*b +: 8];
  endtask

  task automatic drain(input string name);
    chk(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // Monitor: every non-x0 write-back must match the next expected entry
  always @(negedge clk) begin
    if (reset && dut.reg_file.we && dut.reg_file.wa != 5'd0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected rd=%0d got=%h", dut.reg_file.wa, dut.reg_file.wd);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.rd != dut.reg_file.wa || mon_e.val !== dut.reg_file.wd) begin
          errors++;
          $display("FAIL wb got rd=%0d val=%h required rd=%0d val=%h",
                   dut.reg_file.wa, dut.reg_file.wd, mon_e.rd, mon_e.val);
        end
      end
    end
  end

  initial begin
    // Basic ALU program and PC sequence
    reset_dut();
    prog.delete();
    prog.push_back(32'h01000093);
    prog.push_back(32'h00800113);
    prog.push_back(32'h002081B3);
    load_prog();
    expect_wb(1, 64'd16); expect_wb(2, 64'd8); expect_wb(3, 64'd24);
    reset = 1'b1;
    step(1); chk("t1_pc1", dut.if_stage.PC_F, 64'd4);
    step(1); chk("t1_pc2", dut.if_stage.PC_F, 64'd8);
    step(1); chk("t1_pc3", dut.if_stage.PC_F, 64'd12);
    step(4);
    chk("t1_x1", dut.reg_file.regs[1], 64'd16);
    chk("t1_x2", dut.reg_file.regs[2], 64'd8);
    chk("t1_x3", dut.reg_file.regs[3], 64'd24);
    drain("t1_drain");

    // Back-to-back dependency chain, no stall
    reset_dut();
    chk("t2_reset_x3", dut.reg_file.regs[3], 64'd0);
    prog.delete();
    prog.push_back(addi(1, 0, 5));
    repeat (3) prog.push_back(addi(1, 1, 1));
    load_prog();
    expect_wb(1, 64'd5); expect_wb(1, 64'd6); expect_wb(1, 64'd7); expect_wb(1, 64'd8);
    reset = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step(1);
      chk("t2_pc", dut.if_stage.PC_F, 64'(4*i));
    end
    step(4);
    chk("t2_x1", dut.reg_file.regs[1], 64'd8);
    drain("t2_drain");

    // Word ops, shifts, compares and logic
    reset_dut();
    prog.delete();
    prog.push_back(addi(1, 0, -1));                       expect_wb(1, 64'hFFFFFFFFFFFFFFFF);
    prog.push_back(enc_i(1, 1, 0, 2, 'h1B));              expect_wb(2, 64'h0);
    prog.push_back(addi(3, 0, 2047));                     expect_wb(3, 64'h7FF);
    prog.push_back(enc_i(20, 3, 1, 4, 'h13));             expect_wb(4, 64'h7FF00000);
    prog.push_back(enc_r(0, 4, 4, 0, 5, 'h3B));           expect_wb(5, 64'hFFFFFFFFFFE00000);
    prog.push_back(enc_r('h20, 4, 5, 0, 6, 'h3B));        expect_wb(6, 64'h7FF00000);
    prog.push_back(enc_r(0, 0, 1, 2, 8, 'h33));           expect_wb(8, 64'h1);
    prog.push_back(enc_r(0, 0, 1, 3, 9, 'h33));           expect_wb(9, 64'h0);
    prog.push_back(enc_r('h20, 3, 0, 0, 10, 'h33));       expect_wb(10, 64'hFFFFFFFFFFFFF801);
    prog.push_back(enc_i('h404, 10, 5, 11, 'h13));        expect_wb(11, 64'hFFFFFFFFFFFFFF80);
    prog.push_back(enc_i(60, 10, 5, 12, 'h13));           expect_wb(12, 64'hF);
    prog.push_back(enc_i(-1, 3, 4, 13, 'h13));            expect_wb(13, 64'hFFFFFFFFFFFFF800);
    prog.push_back(enc_i(255, 10, 7, 14, 'h13));          expect_wb(14, 64'h1);
    prog.push_back(enc_r(0, 3, 10, 7, 15, 'h33));         expect_wb(15, 64'h1);
    prog.push_back(enc_r(0, 3, 4, 6, 16, 'h33));          expect_wb(16, 64'h7FF007FF);
    prog.push_back(enc_r(0, 14, 3, 1, 17, 'h33));         expect_wb(17, 64'hFFE);
    prog.push_back(enc_r(0, 14, 10, 5, 18, 'h33));        expect_wb(18, 64'h7FFFFFFFFFFFFC00);
    prog.push_back(enc_r('h20, 14, 10, 5, 19, 'h33));     expect_wb(19, 64'hFFFFFFFFFFFFFC00);
    prog.push_back(enc_i(-2048, 10, 2, 20, 'h13));        expect_wb(20, 64'h0);
    prog.push_back(enc_i(-1, 3, 3, 21, 'h13));            expect_wb(21, 64'h1);
    prog.push_back(enc_r(0, 3, 1, 4, 22, 'h33));          expect_wb(22, 64'hFFFFFFFFFFFFF800);
    load_prog();
    reset = 1'b1;
    step(30);
    chk("t3_x2", dut.reg_file.regs[2], 64'h0);
    chk("t3_x5", dut.reg_file.regs[5], 64'hFFFFFFFFFFE00000);
    drain("t3_drain");

    // Store/load forwarding through memory, load-use stall, wrapping access
    reset_dut();
    prog.delete();
    prog.push_back(addi(1, 0, 'h123));     expect_wb(1, 64'h123);
    prog.push_back(enc_s(16, 1, 0));
    prog.push_back(enc_i(16, 0, 3, 4, 'h03)); expect_wb(4, 64'h123);
    prog.push_back(enc_r(0, 4, 4, 0, 5, 'h33)); expect_wb(5, 64'h246);
    prog.push_back(addi(7, 0, -2));        expect_wb(7, 64'hFFFFFFFFFFFFFFFE);
    prog.push_back(enc_s(252, 7, 0));
    prog.push_back(enc_i(252, 0, 3, 8, 'h03)); expect_wb(8, 64'hFFFFFFFFFFFFFFFE);
    load_prog();
    reset = 1'b1;
    step(1); chk("t4_pc1", dut.if_stage.PC_F, 64'd4);
    step(1); chk("t4_pc2", dut.if_stage.PC_F, 64'd8);
    step(1); chk("t4_pc3", dut.if_stage.PC_F, 64'd12);
    step(1); chk("t4_pc4", dut.if_stage.PC_F, 64'd16);
    step(1); chk("t4_pc_stall", dut.if_stage.PC_F, 64'd16);
    step(1); chk("t4_pc6", dut.if_stage.PC_F, 64'd20);
    step(10);
    chk("t4_x5", dut.reg_file.regs[5], 64'h246);
    chk("t4_mem16", 64'(dut.data_mem.mem[16]), 64'h23);
    chk("t4_mem17", 64'(dut.data_mem.mem[17]), 64'h01);
    chk("t4_mem252", 64'(dut.data_mem.mem[252]), 64'hFE);
    chk("t4_mem0_wrap", 64'(dut.data_mem.mem[0]), 64'hFF);
    chk("t4_mem3_wrap", 64'(dut.data_mem.mem[3]), 64'hFF);
    drain("t4_drain");

    // Branches: taken BEQ, not-taken BNE, taken BNE
    reset_dut();
    chk("t5_reset_mem16", 64'(dut.data_mem.mem[16]), 64'h0);
    chk("t5_reset_x8", dut.reg_file.regs[8], 64'h0);
    prog.delete();
    prog.push_back(addi(1, 0, 1));        expect_wb(1, 64'd1);
    prog.push_back(enc_b(8, 0, 0, 0));
    prog.push_back(addi(6, 0, 9));
    prog.push_back(addi(7, 0, 3));        expect_wb(7, 64'd3);
    prog.push_back(enc_b(8, 0, 0, 1));
    prog.push_back(addi(8, 0, 5));        expect_wb(8, 64'd5);
    prog.push_back(enc_b(8, 0, 1, 1));
    prog.push_back(addi(9, 0, 9));
    prog.push_back(addi(10, 0, 10));      expect_wb(10, 64'd10);
    load_prog();
    reset = 1'b1;
    step(1); chk("t5_pc1", dut.if_stage.PC_F, 64'd4);
    step(1); chk("t5_pc2", dut.if_stage.PC_F, 64'd8);
    step(1); chk("t5_pc3", dut.if_stage.PC_F, 64'd12);
    step(1); chk("t5_pc_target", dut.if_stage.PC_F, 64'd12);
    step(1); chk("t5_pc5", dut.if_stage.PC_F, 64'd16);
    step(15);
    chk("t5_x6", dut.reg_file.regs[6], 64'd0);
    chk("t5_x9", dut.reg_file.regs[9], 64'd0);
    chk("t5_x10", dut.reg_file.regs[10], 64'd10);
    drain("t5_drain");

    // x0 write discarded; zero-filled memory runs as NOPs
    reset_dut();
    prog.delete();
    prog.push_back(addi(0, 0, 7));
    prog.push_back(addi(1, 0, 7));        expect_wb(1, 64'd7);
    load_prog();
    reset = 1'b1;
    step(30);
    chk("t6_x0", dut.reg_file.regs[0], 64'd0);
    chk("t6_x1", dut.reg_file.regs[1], 64'd7);
    chk("t6_pc", dut.if_stage.PC_F, 64'd120);
    drain("t6_drain");

    // Reset in mid-program aborts in-flight instructions
    reset_dut();
    chk("t7_reset_x1", dut.reg_file.regs[1], 64'd0);
    prog.delete();
    prog.push_back(32'h01000093);
    prog.push_back(32'h00800113);
    prog.push_back(32'h002081B3);
    load_prog();
    expect_wb(1, 64'd16);
    reset = 1'b1;
    step(5);
    chk("t7_x1_before", dut.reg_file.regs[1], 64'd16);
    reset = 1'b0;
    step(1);
    chk("t7_pc", dut.if_stage.PC_F, 64'd0);
    chk("t7_x1", dut.reg_file.regs[1], 64'd0);
    chk("t7_x2", dut.reg_file.regs[2], 64'd0);
    step(3);
    chk("t7_x2_later", dut.reg_file.regs[2], 64'd0);
    chk("t7_x3_later", dut.reg_file.regs[3], 64'd0);
    drain("t7_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
